uart_rx_core: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_core_if.sv | 18 +
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/uart_rx_core.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and the
// parity helper used by both the receive and (future) transmit paths.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    // Widest data word any UART variant carries; parity is computed on a
    // zero-extended word of this width so one function serves all widths.
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Parity bit that makes XOR(data, parity) equal 1 for odd, 0 for even.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] d,
                                        input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-side word channel between the UART receiver and the CPU bus.
// Handshake: the receiver raises valid with data and flags; all of them stay
// stable until the consumer samples valid && ready on a rising clock edge,
// which is the one and only transfer point. ready may be driven freely.
interface uart_rx_core_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;

    modport master (output data, valid, parity_err, frame_err, break_det, overrun,
                    input  ready);
    modport slave  (input  data, valid, parity_err, frame_err, break_det, overrun,
                    output ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: latches the divisor on load, then counts down
// and emits a one-clock tick each time the counter reaches zero.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Next-state: load latches the divisor, otherwise count down and reload.
    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (load_i) begin
            div_d = div_i;
            cnt_d = div_i;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? div_q : cnt_q - DIV_W'(1);
        end
    end

    // Divisor latch and down-counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !load_i && (cnt_q == '0);
endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: synchronises RX, majority-votes each bit,
// checks parity/stop bits, and presents words through a valid/ready channel.
module uart_rx_core import uart_pkg::*; #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [DIV_W-1:0]   baud_div_i,
    input  logic               rx_i,
    uart_rx_core_if.master     rx_bus,
    output rx_state_t          state_o
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_DEC  = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    logic                 sync1_q, sync2_q, rx_prev_q;
    rx_state_t            state_q;
    logic [TICK_W-1:0]    tick_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [1:0]           samp_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q, stop_err_q, stop_one_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, pe_q, fe_q, bk_q, ovr_q;

    logic rx_s, fall, tick, at_dec, at_end, dec, last_stop, done, accept;
    logic pe_new, fe_new, bk_new;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx_i;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    assign rx_s = sync2_q;
    assign fall = rx_prev_q && !rx_s;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i ((state_q == ST_IDLE) && fall),
        .en_i   ((state_q != ST_IDLE) && (state_q != ST_WAIT_HIGH)),
        .div_i  (baud_div_i),
        .tick_o (tick)
    );

    // Bit decision, frame completion and the flags of the completing frame.
    always_comb begin
        at_dec    = tick && (tick_cnt_q == TICK_DEC);
        at_end    = tick && (tick_cnt_q == TICK_LAST);
        dec       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
        last_stop = (bit_cnt_q == BIT_W'(STOP_BITS - 1));
        done      = (state_q == ST_STOP) && at_dec && last_stop;
        pe_new    = (PARITY != 0) &&
                    (par_q != parity_bit(MAX_DATA_BITS'(shift_q), 2'(PARITY)));
        fe_new    = stop_err_q || !dec;
        bk_new    = (shift_q == '0) && ((PARITY == 0) || !par_q) && !stop_one_q && !dec;
        accept    = valid_q && rx_bus.ready;
    end

    // Receive FSM: tick/bit counting, sampling, shifting and stop checking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_err_q <= 1'b0;
            stop_one_q <= 1'b0;
        end else begin
            if (tick) begin
                tick_cnt_q <= (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
                if (tick_cnt_q == TICK_S0) samp_q[0] <= rx_s;
                if (tick_cnt_q == TICK_S1) samp_q[1] <= rx_s;
            end
            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_q    <= ST_START;
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        stop_err_q <= 1'b0;
                        stop_one_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (at_dec && dec) state_q <= ST_IDLE;   // false start
                    else if (at_end)   state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (at_dec) begin
                        shift_q   <= {dec, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                    if (at_end && (bit_cnt_q == BIT_W'(DATA_BITS))) begin
                        state_q   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        bit_cnt_q <= '0;
                    end
                end
                ST_PARITY: begin
                    if (at_dec) par_q   <= dec;
                    if (at_end) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    if (at_dec) begin
                        stop_err_q <= stop_err_q | ~dec;
                        stop_one_q <= stop_one_q | dec;
                        // Complete at the decision point so a back-to-back start is seen.
                        if (last_stop) state_q <= dec ? ST_IDLE : ST_WAIT_HIGH;
                    end else if (at_end) begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) state_q <= ST_IDLE;   // no retrigger while the line is held low
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output holding registers and valid/ready handshake with overrun tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            bk_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (done && (!valid_q || accept)) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            pe_q    <= pe_new;
            fe_q    <= fe_new;
            bk_q    <= bk_new;
            ovr_q   <= 1'b0;
        end else if (done) begin
            ovr_q   <= 1'b1;   // new frame dropped, held word untouched
        end else if (accept) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign rx_bus.data       = data_q;
    assign rx_bus.valid      = valid_q;
    assign rx_bus.parity_err = pe_q;
    assign rx_bus.frame_err  = fe_q;
    assign rx_bus.break_det  = bk_q;
    assign rx_bus.overrun    = ovr_q;
    assign state_o           = state_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1 instance and an 8E2 instance share one
// clock; frames are driven bit by bit and accepted words are compared with
// constant tables and a frame-level reference model.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int BIT_CLKS = 64;   // OVERSAMPLE 16 * (baud_div 3 + 1)

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
        logic       ov;
    } rec_t;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic [1:0] stops;   // stops[0] is the first stop bit on the line
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_bk;
    } vec_t;

    // ---------------- clock / reset / DUTs ----------------
    logic        clk = 1'b0;
    logic        rst_a, rst_b, rx_a, rx_b;
    logic [15:0] baud_div;
    rx_state_t   state_a, state_b;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_core_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_core_if #(.DATA_BITS(8)) bus_b ();

    uart_rx_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .baud_div_i(baud_div), .rx_i(rx_a),
        .rx_bus(bus_a), .state_o(state_a));

    uart_rx_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(16), .DIV_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .baud_div_i(baud_div), .rx_i(rx_b),
        .rx_bus(bus_b), .state_o(state_b));

    // ---------------- scoreboard / monitor ----------------
    int   n_vec = 0;
    int   n_err = 0;
    rec_t got_a[$];
    rec_t got_b[$];
    rec_t exp_q[$];
    int   rises_a = 0, rises_b = 0, rise_cyc_a = 0, fall_cyc = 0;
    logic vprev_a = 1'b0, vprev_b = 1'b0;

    function automatic rec_t mk_rec(input logic [7:0] d, input logic pe, input logic fe,
                                    input logic bk, input logic ov);
        rec_t r;
        r.d = d; r.pe = pe; r.fe = fe; r.bk = bk; r.ov = ov;
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus_a.valid && bus_a.ready)
            got_a.push_back(mk_rec(bus_a.data, bus_a.parity_err, bus_a.frame_err,
                                   bus_a.break_det, bus_a.overrun));
        if (bus_b.valid && bus_b.ready)
            got_b.push_back(mk_rec(bus_b.data, bus_b.parity_err, bus_b.frame_err,
                                   bus_b.break_det, bus_b.overrun));
        if (bus_a.valid && !vprev_a) begin
            rises_a++;
            rise_cyc_a = cyc;
        end
        if (bus_b.valid && !vprev_b) rises_b++;
        vprev_a = bus_a.valid;
        vprev_b = bus_b.valid;
    end

    // Frame-level reference: parity by counting ones, errors from the stop list.
    function automatic rec_t model(input logic [7:0] d, input int par_mode, input logic p,
                                   input int nstop, input logic [1:0] stops);
        rec_t r;
        int   ones = $countones(d) + ((par_mode != 0) ? int'(p) : 0);
        int   zeros_in_stop = 0;
        for (int i = 0; i < nstop; i++) if (!stops[i]) zeros_in_stop++;
        r.d  = d;
        r.pe = (par_mode == 1) ? (ones % 2 == 0) : (par_mode == 2) ? (ones % 2 == 1) : 1'b0;
        r.fe = (zeros_in_stop > 0);
        r.bk = (d == 8'h00) && (par_mode == 0 || p == 1'b0) && (zeros_in_stop == nstop);
        r.ov = 1'b0;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rec(input string name, input rec_t g, input rec_t e);
        check({name, ".data"}, 32'(g.d), 32'(e.d));
        check({name, ".parity_err"}, 32'(g.pe), 32'(e.pe));
        check({name, ".frame_err"}, 32'(g.fe), 32'(e.fe));
        check({name, ".break_det"}, 32'(g.bk), 32'(e.bk));
        check({name, ".overrun"}, 32'(g.ov), 32'(e.ov));
    endtask

    // ---------------- drivers ----------------
    // Called and returning at posedge+1, holding the line for one bit time.
    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rx_a = v; else rx_b = v;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic has_par,
                              input logic p, input int nstop, input logic [1:0] stops,
                              input int idle_bits);
        fall_cyc = cyc;
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (has_par) drive_bit(which, p);
        for (int i = 0; i < nstop; i++) drive_bit(which, stops[i]);
        for (int i = 0; i < idle_bits; i++) drive_bit(which, 1'b1);
    endtask

    // Expect exactly one accepted word on a port and compare it.
    task automatic expect_one(input string name, input int which, input rec_t e);
        int sz = (which == 0) ? got_a.size() : got_b.size();
        check({name, ".count"}, 32'(sz), 32'd1);
        if (sz > 0) check_rec(name, (which == 0) ? got_a[0] : got_b[0], e);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    vec_t vecs[9];
    rec_t e;
    logic [7:0] rd;
    logic [1:0] rstops;
    logic rp;

    initial begin
        vecs[0] = '{8'h07, 1'b0, 2'b11, 8'h07, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 2'b11, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'hA5, 1'b1, 2'b11, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 2'b01, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 1'b1, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{8'h80, 1'b1, 2'b10, 8'h80, 1'b0, 1'b1, 1'b0};

        baud_div    = 16'd3;
        rx_a        = 1'b1;
        rx_b        = 1'b1;
        rst_a       = 1'b1;
        rst_b       = 1'b1;
        bus_a.ready = 1'b1;
        bus_b.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check_rec("reset_a", mk_rec(bus_a.data, bus_a.parity_err, bus_a.frame_err,
                                    bus_a.break_det, bus_a.overrun), mk_rec(8'h00, 0, 0, 0, 0));
        check("reset_a.valid", 32'(bus_a.valid), 32'd0);
        check("reset_b.valid", 32'(bus_b.valid), 32'd0);
        check("reset_a.state", 32'(state_a), 32'(ST_IDLE));
        check("reset_b.state", 32'(state_b), 32'(ST_IDLE));
        @(posedge clk);
        #1;

        // 8N1 basic frame and its latency window
        got_a.delete();
        rises_a = 0;
        send_frame(0, 8'h55, 1'b0, 1'b0, 1, 2'b11, 2);
        expect_one("t1_55", 0, mk_rec(8'h55, 0, 0, 0, 0));
        check("t1_valid_pulses", 32'(rises_a), 32'd1);
        check("t1_latency_in_window",
              32'((rise_cyc_a - fall_cyc) >= 9 * BIT_CLKS && (rise_cyc_a - fall_cyc) <= 10 * BIT_CLKS),
              32'd1);

        // short low glitch is a false start
        got_a.delete();
        rises_a = 0;
        rx_a = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rx_a = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1;
        check("t2_glitch_valid_pulses", 32'(rises_a), 32'd0);
        check("t2_glitch_state", 32'(state_a), 32'(ST_IDLE));
        send_frame(0, 8'hA3, 1'b0, 1'b0, 1, 2'b11, 2);
        expect_one("t2_A3", 0, mk_rec(8'hA3, 0, 0, 0, 0));

        // parity and stop-bit table on the 8E2 instance
        for (int i = 0; i < 9; i++) begin
            got_b.delete();
            send_frame(1, vecs[i].d, 1'b1, vecs[i].p, 2, vecs[i].stops, 2);
            expect_one($sformatf("tbl%0d", i), 1,
                       mk_rec(vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_bk, 1'b0));
        end

        // line break: 20 bit times low yields one break frame, then silence
        got_b.delete();
        rises_b = 0;
        for (int i = 0; i < 20; i++) drive_bit(1, 1'b0);
        check("t4_break_state", 32'(state_b), 32'(ST_WAIT_HIGH));
        for (int i = 0; i < 2; i++) drive_bit(1, 1'b1);
        expect_one("t4_break", 1, mk_rec(8'h00, 0, 1, 1, 0));
        check("t4_break_valid_pulses", 32'(rises_b), 32'd1);
        got_b.delete();
        send_frame(1, 8'h5A, 1'b1, 1'b0, 2, 2'b11, 2);
        expect_one("t4_after_break", 1, mk_rec(8'h5A, 0, 0, 0, 0));

        // overrun: two back-to-back frames with the consumer stalled
        got_a.delete();
        bus_a.ready = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1, 2'b11, 0);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1, 2'b11, 2);
        check("t5_held_valid", 32'(bus_a.valid), 32'd1);
        check("t5_held_data", 32'(bus_a.data), 32'h11);
        check("t5_held_overrun", 32'(bus_a.overrun), 32'd1);
        bus_a.ready = 1'b1;
        @(posedge clk);
        #1;
        bus_a.ready = 1'b0;
        @(negedge clk);
        check("t5_valid_after_accept", 32'(bus_a.valid), 32'd0);
        check("t5_overrun_after_accept", 32'(bus_a.overrun), 32'd0);
        expect_one("t5_accepted", 0, mk_rec(8'h11, 0, 0, 0, 1));
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1;
        check("t5_no_second_word", 32'(bus_a.valid), 32'd0);
        bus_a.ready = 1'b1;

        // reset in the middle of the data bits of 0x3C
        got_a.delete();
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, rd_bit(8'h3C, i));
        check("t6_mid_state", 32'(state_a), 32'(ST_DATA));
        rst_a = 1'b1;
        rx_a  = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        @(negedge clk);
        check_rec("t6_after_reset", mk_rec(bus_a.data, bus_a.parity_err, bus_a.frame_err,
                                           bus_a.break_det, bus_a.overrun), mk_rec(8'h00, 0, 0, 0, 0));
        check("t6_after_reset.valid", 32'(bus_a.valid), 32'd0);
        check("t6_after_reset.state", 32'(state_a), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1, 2'b11, 2);
        expect_one("t6_C3", 0, mk_rec(8'hC3, 0, 0, 0, 0));

        // randomized 8E2 frames against the reference model
        for (int i = 0; i < 16; i++) begin
            got_b.delete();
            rd     = 8'($urandom_range(0, 255));
            rp     = (^rd) ^ ($urandom_range(0, 3) == 0);
            rstops = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            exp_q.push_back(model(rd, 2, rp, 2, rstops));
            send_frame(1, rd, 1'b1, rp, 2, rstops, 2);
            e = exp_q.pop_front();
            expect_one($sformatf("rnd%0d", i), 1, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic logic rd_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
